// File: rtl/ritc_phase_scan_controller.sv
// ritc_phase_scan_controller
//
// Runs a RITC phase scan in the user clock domain. For each step the
// controller waits for the sampled inputs to settle and requests a scan from
// the phase-scanner registers. After the 2-flop resync it latches the scanner
// outputs and offers them to the readout as a 40-bit snapshot. Once the
// snapshot has been transferred, it advances the MMCM fine phase by one
// increment and waits for PSDONE.
//
// Ports
//   user_clk_i, user_rst_i      clock, synchronous active-high reset
//   start_i, abort_i, nsteps_i  scan control; nsteps_i is latched on an accepted start
//   ps_en_o, ps_incdec_o        MMCM PSEN pulse, PSINCDEC (always increment)
//   ps_done_i                   MMCM PSDONE
//   user_scan_o                 one-cycle scan request to the phase scanner
//   clk_q_i .. vcdl_q_i         resynchronized scanner outputs
//   result_valid_o/ready_i      snapshot handshake
//   result_data_o               {vcdl, ch2, ch1, ch0, clk}
//   result_step_o               step index of snapshot (0 = starting phase)
//   busy_o, done_o, timeout_o   status; timeout_o is sticky until next start
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_SETTLE  | letting sampled inputs settle after start or phase step
// ST_SCAN    | one-cycle scan request
// ST_CAPTURE | waiting out resync, snapshot latched on last cycle
// ST_OUTPUT  | snapshot offered to readout
// ST_PS_REQ  | one-cycle PSEN
// ST_PS_WAIT | waiting for PSDONE (abort deferred until it arrives)
// ST_DONE    | one-cycle completion pulse

module ritc_phase_scan_controller #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int CAPTURE_CYCLES = 4,
    parameter int PS_TIMEOUT     = 256,
    parameter int STEP_BITS      = 10
) (
    input  logic                 user_clk_i,
    input  logic                 user_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [STEP_BITS-1:0] nsteps_i,
    output logic                 ps_en_o,
    output logic                 ps_incdec_o,
    input  logic                 ps_done_i,
    output logic                 user_scan_o,
    input  logic [2:0]           clk_q_i,
    input  logic [11:0]          ch0_q_i,
    input  logic [11:0]          ch1_q_i,
    input  logic [11:0]          ch2_q_i,
    input  logic                 vcdl_q_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [39:0]          result_data_o,
    output logic [STEP_BITS-1:0] result_step_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);

    // One shared down-counter times all three waits, so it is sized for the longest.
    localparam int TMR_MAX_A = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > PS_TIMEOUT) ? TMR_MAX_A : PS_TIMEOUT;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] CAPTURE_LOAD = TMR_W'(CAPTURE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PS_LOAD      = TMR_W'(PS_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_CAPTURE,
        ST_OUTPUT,
        ST_PS_REQ,
        ST_PS_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [STEP_BITS-1:0]   step_q, step_d;
    logic [STEP_BITS-1:0]   nsteps_q, nsteps_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   timeout_q, timeout_d;
    logic [39:0]            res_data_q, res_data_d;
    logic [STEP_BITS-1:0]   res_step_q, res_step_d;

    logic [STEP_BITS-1:0]   step_inc;
    logic                   abort_eff;
    logic                   ps_en_c;
    logic                   scan_c;
    logic                   valid_c;
    logic                   done_c;

    assign step_inc  = step_q + 1'b1;
    // A PSEN is outstanding in PS_WAIT, so an abort there is remembered, not acted on.
    assign abort_eff = abort_i | abort_pend_q;

    always_ff @(posedge user_clk_i) begin
        if (user_rst_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            step_q       <= '0;
            nsteps_q     <= '0;
            abort_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
            res_data_q   <= '0;
            res_step_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            step_q       <= step_d;
            nsteps_q     <= nsteps_d;
            abort_pend_q <= abort_pend_d;
            timeout_q    <= timeout_d;
            res_data_q   <= res_data_d;
            res_step_q   <= res_step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        step_d       = step_q;
        nsteps_d     = nsteps_q;
        abort_pend_d = abort_pend_q;
        timeout_d    = timeout_q;
        res_data_d   = res_data_q;
        res_step_d   = res_step_q;
        ps_en_c      = 1'b0;
        scan_c       = 1'b0;
        valid_c      = 1'b0;
        done_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_i && !abort_i) begin
                    nsteps_d  = nsteps_i;
                    timeout_d = 1'b0;
                    step_d    = '0;
                    timer_d   = SETTLE_LOAD;
                    state_d   = (nsteps_i != '0) ? ST_SETTLE : ST_DONE;
                end
            end

            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_SCAN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_SCAN: begin
                scan_c = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = CAPTURE_LOAD;
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    res_data_d = {vcdl_q_i, ch2_q_i, ch1_q_i, ch0_q_i, clk_q_i};
                    res_step_d = step_q;
                    state_d    = ST_OUTPUT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_OUTPUT: begin
                valid_c = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (result_ready_i) begin
                    step_d  = step_inc;
                    state_d = (step_inc == nsteps_q) ? ST_DONE : ST_PS_REQ;
                end
            end

            ST_PS_REQ: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    ps_en_c      = 1'b1;
                    timer_d      = PS_LOAD;
                    abort_pend_d = 1'b0;
                    state_d      = ST_PS_WAIT;
                end
            end

            ST_PS_WAIT: begin
                abort_pend_d = abort_eff;
                if (ps_done_i) begin
                    timer_d = SETTLE_LOAD;
                    state_d = abort_eff ? ST_IDLE : ST_SETTLE;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = abort_eff ? ST_IDLE : ST_DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ps_en_o        = ps_en_c;
    assign ps_incdec_o    = 1'b1;
    assign user_scan_o    = scan_c;
    assign result_valid_o = valid_c;
    assign result_data_o  = res_data_q;
    assign result_step_o  = res_step_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_c;
    assign timeout_o      = timeout_q;

endmodule
